// File: rtl/nibble_deserializer.sv
// Serial-to-parallel nibble receiver: frames 4 bits from a serial stream (MSB- or LSB-first)
// and presents each completed word on a registered valid/ready output.
//
// state  | meaning
// -------+----------------------------------------------------
// S_IDLE | waiting for a FRAME-qualified first bit
// S_RECV | collecting bits; cnt_q = bits already captured (1..3)
module nibble_deserializer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enb_i,
    input  logic       dir_i,
    input  logic       frame_i,
    input  logic       s_in_i,
    input  logic       ready_i,
    input  logic       clr_i,
    output logic [3:0] q_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       sync_err_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sh_q, sh_d;
    logic [1:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic [3:0] q_q, q_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       sync_err_q, sync_err_d;
    logic       overrun_set;
    logic       sync_set;

    // dir=0 shifts toward the MSB (MSB-first stream), dir=1 toward the LSB.
    function automatic logic [3:0] insert_bit(input logic [3:0] sh, input logic b, input logic dir);
        insert_bit = dir ? {b, sh[3:1]} : {sh[2:0], b};
    endfunction

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        q_d         = q_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;
        sync_set    = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (enb_i) begin
            if (frame_i) begin
                // A frame start in RECV is a resync: the partial word is simply overwritten.
                sync_set = (state_q == S_RECV);
                dir_d    = dir_i;
                sh_d     = insert_bit(sh_q, s_in_i, dir_i);
                cnt_d    = 2'd1;
                state_d  = S_RECV;
            end else if (state_q == S_RECV) begin
                sh_d  = insert_bit(sh_q, s_in_i, dir_q);
                cnt_d = 2'(cnt_q + 2'd1);
                if (cnt_q == 2'd3) begin
                    state_d = S_IDLE;
                    if (!valid_q || ready_i) begin
                        q_d     = sh_d;
                        valid_d = 1'b1;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end
            end
        end

        overrun_d  = overrun_set | (overrun_q & ~clr_i);
        sync_err_d = sync_set | (sync_err_q & ~clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sh_q       <= 4'b0000;
            cnt_q      <= 2'd0;
            dir_q      <= 1'b0;
            q_q        <= 4'b0000;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign q_o        = q_q;
    assign valid_o    = valid_q;
    assign busy_o     = (state_q == S_RECV);
    assign overrun_o  = overrun_q;
    assign sync_err_o = sync_err_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: directed scenarios plus random back-to-back frames,
// with delivered words checked against a queue of expected nibbles.
module tb_nibble_deserializer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       enb_i = 1'b0;
    logic       dir_i = 1'b0;
    logic       frame_i = 1'b0;
    logic       s_in_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [3:0] q_o;
    logic       valid_o;
    logic       busy_o;
    logic       overrun_o;
    logic       sync_err_o;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] sb[$];

    nibble_deserializer dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enb_i      (enb_i),
        .dir_i      (dir_i),
        .frame_i    (frame_i),
        .s_in_i     (s_in_i),
        .ready_i    (ready_i),
        .clr_i      (clr_i),
        .q_o        (q_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o),
        .sync_err_o (sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Any transfer happening on the coming edge is scored here, then outputs are sampled 1 after it.
    task automatic tick();
        logic [3:0] exp_w;
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_word", 4'(sb.size()), 4'd1);
            end else begin
                exp_w = sb.pop_front();
                check_eq("sb_word", q_o, exp_w);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [3:0] expected_word(input logic [3:0] s, input logic dir);
        logic [3:0] w;
        for (int k = 0; k < 4; k++) w[k] = dir ? s[3-k] : s[k];
        return w;
    endfunction

    // s[3] is the first bit on the wire.
    task automatic send_frame(input logic [3:0] s, input logic dir, input int gap,
                              input bit push, input bit rdy_last);
        logic v0;
        v0 = valid_o;
        if (push) sb.push_back(expected_word(s, dir));
        for (int i = 0; i < 4; i++) begin
            enb_i   = 1'b1;
            frame_i = (i == 0);
            dir_i   = dir;
            s_in_i  = s[3-i];
            if (rdy_last && i == 3) ready_i = 1'b1;
            tick();
            check_eq("busy", {3'b0, busy_o}, {3'b0, (i != 3)});
            if (!v0 && i != 3) check_eq("valid_early", {3'b0, valid_o}, 4'd0);
            if (i == 1 && gap > 0) begin
                enb_i  = 1'b0;
                s_in_i = ~s_in_i;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (!v0) check_eq("valid_gap", {3'b0, valid_o}, 4'd0);
                    check_eq("busy_gap", {3'b0, busy_o}, 4'd1);
                end
            end
        end
        enb_i   = 1'b0;
        frame_i = 1'b0;
        if (rdy_last) ready_i = 1'b0;
    endtask

    task automatic send_partial(input logic b1, input logic b2);
        enb_i = 1'b1; dir_i = 1'b0; frame_i = 1'b1; s_in_i = b1;
        tick();
        frame_i = 1'b0; s_in_i = b2;
        tick();
        enb_i = 1'b0;
    endtask

    task automatic consume();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_eq("valid_after_xfer", {3'b0, valid_o}, 4'd0);
    endtask

    initial begin
        logic [3:0] rs;
        logic       rd;

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("rst_q", q_o, 4'b0000);
        check_eq("rst_valid", {3'b0, valid_o}, 4'd0);
        check_eq("rst_busy", {3'b0, busy_o}, 4'd0);
        check_eq("rst_overrun", {3'b0, overrun_o}, 4'd0);
        check_eq("rst_sync", {3'b0, sync_err_o}, 4'd0);

        send_frame(4'b1011, 1'b0, 0, 1'b1, 1'b0);
        check_eq("left_q", q_o, 4'b1011);
        check_eq("left_valid", {3'b0, valid_o}, 4'd1);
        consume();

        send_frame(4'b1000, 1'b1, 2, 1'b1, 1'b0);
        check_eq("right_q", q_o, 4'b0001);
        check_eq("right_valid", {3'b0, valid_o}, 4'd1);
        consume();

        send_frame(4'b1100, 1'b0, 0, 1'b1, 1'b0);
        send_frame(4'b0011, 1'b0, 0, 1'b0, 1'b0);
        check_eq("ovr_q", q_o, 4'b1100);
        check_eq("ovr_flag", {3'b0, overrun_o}, 4'd1);
        consume();
        check_eq("ovr_sticky", {3'b0, overrun_o}, 4'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_eq("ovr_clr", {3'b0, overrun_o}, 4'd0);

        send_frame(4'b0101, 1'b0, 0, 1'b1, 1'b0);
        send_frame(4'b1110, 1'b0, 0, 1'b1, 1'b1);
        check_eq("simul_q", q_o, 4'b1110);
        check_eq("simul_valid", {3'b0, valid_o}, 4'd1);
        check_eq("simul_overrun", {3'b0, overrun_o}, 4'd0);
        consume();

        send_partial(1'b1, 1'b1);
        check_eq("resync_pre_sync", {3'b0, sync_err_o}, 4'd0);
        send_frame(4'b0110, 1'b0, 0, 1'b1, 1'b0);
        check_eq("resync_flag", {3'b0, sync_err_o}, 4'd1);
        check_eq("resync_q", q_o, 4'b0110);
        consume();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_eq("sync_clr", {3'b0, sync_err_o}, 4'd0);

        send_frame(4'b1111, 1'b0, 0, 1'b1, 1'b0);
        check_eq("pre_rst_q", q_o, 4'b1111);
        send_partial(1'b1, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sb.delete();
        check_eq("midrst_q", q_o, 4'b0000);
        check_eq("midrst_valid", {3'b0, valid_o}, 4'd0);
        check_eq("midrst_busy", {3'b0, busy_o}, 4'd0);
        check_eq("midrst_sync", {3'b0, sync_err_o}, 4'd0);
        send_frame(4'b1001, 1'b0, 0, 1'b1, 1'b0);
        check_eq("postrst_q", q_o, 4'b1001);
        consume();

        ready_i = 1'b1;
        for (int n = 0; n < 10; n++) begin
            rs = 4'($urandom_range(0, 15));
            rd = 1'($urandom_range(0, 1));
            send_frame(rs, rd, 0, 1'b1, 1'b0);
            ready_i = 1'b1;
        end
        check_eq("b2b_overrun", {3'b0, overrun_o}, 4'd0);
        tick();
        tick();
        ready_i = 1'b0;
        check_eq("sb_drained", 4'(sb.size()), 4'd0);
        check_eq("final_valid", {3'b0, valid_o}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_deserializer.md
# nibble_deserializer

Serial-to-parallel receiver for the 4-bit shift register's serial output. It captures framed 4-bit words from a serial stream: either a register's S_OUT, or a chain of registers in SHIFT mode. The bit order is selected by DIR, with the same LEFT/RIGHT convention as the register. Each completed nibble is presented on a parallel output register behind a valid/ready handshake. It sits on the far end of a register chain and returns serialized data to parallel logic.

## Interface
- No parameters; fixed 4-bit word width, 2-bit bit counter.
- CLK  input  1  clock; all state updates on posedge CLK.
- RST  input  1  synchronous reset, active-high; overrides every other input.
- ENB  input  1  bit-strobe enable, active-high; S_IN and FRAME are sampled only in cycles with ENB=1.
- DIR  input  1  0 (LEFT): stream is MSB first. 1 (RIGHT): stream is LSB first. Latched at frame start.
- FRAME  input  1  marks the first bit of a nibble; qualified by ENB.
- S_IN  input  1  serial data in.
- READY  input  1  consumer accepts Q when VALID=1.
- CLR  input  1  clears the sticky OVERRUN and SYNC_ERR flags.
- Q  output  4  received nibble; held stable while VALID=1.
- VALID  output  1  Q holds an unconsumed nibble.
- BUSY  output  1  a frame is in progress (state RECV).
- OVERRUN  output  1  sticky; a completed nibble was dropped because the output was still occupied.
- SYNC_ERR  output  1  sticky; FRAME arrived mid-nibble.

## Operation
- States:
  - IDLE: waiting for a frame.
  - RECV: collecting bits; cnt = number of bits already captured (1..3).
- Internal state: shift register sh[3:0], 2-bit cnt, latched dir_l.
- Bit insertion, shared by every capture (current bit = S_IN):
  - LEFT (dir_l=0): sh <= {sh[2:0], S_IN}.
  - RIGHT (dir_l=1): sh <= {S_IN, sh[3:1]}.
  - The first bit uses the DIR input directly rather than dir_l.
- IDLE, ENB=1 and FRAME=1:
  - Latch dir_l <= DIR.
  - Capture S_IN as bit 1, set cnt=1, go to RECV.
- IDLE, ENB=1 and FRAME=0: S_IN is ignored; stay IDLE.
- RECV, ENB=1 and FRAME=0: capture S_IN and cnt <= cnt+1.
  - If cnt was 3, the nibble is complete: go to IDLE and perform the completion action.
- RECV, ENB=1 and FRAME=1 (resync):
  - Discard the partial nibble and set SYNC_ERR.
  - Restart with this bit as bit 1: re-latch DIR, cnt=1, stay in RECV.
- ENB=0: no state change in either state. Gaps between bits are legal.
- Completion action (word w = sh after the 4th insertion):
  - VALID=0, or VALID=1 with READY=1 in the same cycle: Q <= w and VALID <= 1.
  - VALID=1 with READY=0: w is dropped, Q is unchanged, OVERRUN <= 1.
- Handshake:
  - A transfer occurs on any edge with VALID=1 and READY=1.
  - VALID falls after a transfer unless a completion loads a new word on the same edge.
  - READY is ignored when VALID=0.
- CLR=1 clears OVERRUN and SYNC_ERR.
  - If a set event occurs on the same edge, set wins.
- Data flags come only from the serial path; DIR is never re-sampled mid-frame except on resync.

## Timing
- Reset (RST=1 at an edge):
  - State IDLE, cnt=0, sh=0, dir_l=0.
  - Q=4'b0000, VALID=0, BUSY=0, OVERRUN=0, SYNC_ERR=0.
  - Applies mid-frame: the partial nibble is lost and there is no error flag.
- Latency:
  - Q and VALID update on the same edge that samples the 4th bit. They are visible the cycle after that bit's ENB cycle.
  - With ENB held at 1, a frame occupies 4 cycles: FRAME at edge t, VALID=1 after edge t+3.
- Back-to-back frames:
  - FRAME may be asserted on the ENB cycle immediately after the 4th bit; no gap cycle is needed.
  - With READY tied high, one nibble is delivered every 4 cycles with no overrun.
- BUSY is registered: 1 exactly while the state is RECV.
- Outputs are registered only; nothing is combinational from the inputs.

## Test plan
- Reset then LEFT frame:
  - Stimulus: RST 1 cycle; DIR=0, ENB=1, FRAME on bit 1, S_IN=1,0,1,1.
  - Response: Q=4'b1011, VALID=1 one cycle after the 4th bit, BUSY=1 for bits 1-3 only.
- RIGHT frame with gaps:
  - Stimulus: DIR=1, S_IN=1,0,0,0, ENB low for 2 cycles between bits 2 and 3.
  - Response: Q=4'b0001, and VALID rises only after the 4th ENB-qualified bit.
- Overrun:
  - Stimulus: READY=0; two consecutive frames 1100 then 0011, both LEFT.
  - Response: Q stays 4'b1100, OVERRUN=1 after the 2nd frame completes. Then READY=1 for 1 cycle: VALID=0. CLR=1: OVERRUN=0.
- Simultaneous completion and transfer:
  - Stimulus: Q=4'b0101 valid, READY=1 on the same edge as the 4th bit of 1110 (LEFT).
  - Response: Q=4'b1110, VALID stays 1, OVERRUN=0.
- Resync:
  - Stimulus: start LEFT frame 1,1; FRAME again with bits 0,1,1,0.
  - Response: SYNC_ERR=1, Q=4'b0110, and no word is delivered for the partial frame.
- Reset mid-frame:
  - Stimulus: RST=1 after 2 bits, with VALID=1 and Q=4'b1111 beforehand.
  - Response: Q=0, VALID=0, BUSY=0. A following full frame 1001 LEFT yields Q=4'b1001.
